// File: rtl/regfile_pkg.sv
// ============================================================================
// Module      : regfile_pkg
// Description : Shared constants and difftest (un)flatten helpers for regfile_sb.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package regfile_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_NREG   = 32;
    localparam int ZERO_IDX       = 0;

    typedef logic [DEFAULT_NREG*DEFAULT_DATA_W-1:0] rf_flat_t;
    typedef logic [DEFAULT_DATA_W-1:0]              rf_word_t;

    // Extract register r from a flattened difftest image.
    function automatic rf_word_t rf_unflatten(input rf_flat_t flat, input int unsigned r);
        return flat[r*DEFAULT_DATA_W +: DEFAULT_DATA_W];
    endfunction

    // Return a flattened image with register r replaced by val.
    function automatic rf_flat_t rf_flatten(input rf_flat_t flat, input int unsigned r,
                                            input rf_word_t val);
        rf_flat_t v_out;
        v_out = flat;
        v_out[r*DEFAULT_DATA_W +: DEFAULT_DATA_W] = val;
        return v_out;
    endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_sb_if.sv
// ============================================================================
// Module      : regfile_sb_if
// Description : Read, write-back and issue-claim bundle of the register file.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface regfile_sb_if
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int NREG   = DEFAULT_NREG,
    parameter int ADDR_W = $clog2(NREG),
    parameter int NRD    = 4,
    parameter int NWR    = 2
);
    logic [NRD*ADDR_W-1:0] rd_idx;
    logic [NRD*DATA_W-1:0] rd_data;
    logic [NRD-1:0]        rd_busy;
    logic [NWR-1:0]        wb_en;
    logic [NWR*ADDR_W-1:0] wb_idx;
    logic [NWR*DATA_W-1:0] wb_data;
    logic                  iss_valid;
    logic [ADDR_W-1:0]     iss_idx;
    logic                  iss_ready;

    modport master (
        output rd_idx, wb_en, wb_idx, wb_data, iss_valid, iss_idx,
        input  rd_data, rd_busy, iss_ready
    );

    modport slave (
        input  rd_idx, wb_en, wb_idx, wb_data, iss_valid, iss_idx,
        output rd_data, rd_busy, iss_ready
    );
endinterface

`default_nettype wire

// File: rtl/regfile_fwd_mux.sv
// ============================================================================
// Module      : regfile_fwd_mux
// Description : One read port: zero-index check, write-back forwarding, busy.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module regfile_fwd_mux
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int NREG   = DEFAULT_NREG,
    parameter int ADDR_W = $clog2(NREG),
    parameter int NWR    = 2
) (
    input  wire logic [ADDR_W-1:0]      i_idx,
    input  wire logic [NWR-1:0]         i_wb_en,
    input  wire logic [NWR*ADDR_W-1:0]  i_wb_idx,
    input  wire logic [NWR*DATA_W-1:0]  i_wb_data,
    input  wire logic [NREG*DATA_W-1:0] i_rf,
    input  wire logic [NREG-1:0]        i_busy,
    output logic      [DATA_W-1:0]      o_data,
    output logic                        o_busy
);
    logic              w_hit;
    logic [DATA_W-1:0] w_fwd;

    // Ascending scan lets the highest-numbered matching port win.
    always_comb begin
        w_hit = 1'b0;
        w_fwd = i_rf[int'(i_idx)*DATA_W +: DATA_W];
        for (int p = 0; p < NWR; p++) begin
            if (i_wb_en[p] && (i_wb_idx[p*ADDR_W +: ADDR_W] == i_idx)) begin
                w_hit = 1'b1;
                w_fwd = i_wb_data[p*DATA_W +: DATA_W];
            end
        end
        if (i_idx == ADDR_W'(ZERO_IDX)) begin
            o_data = '0;
            o_busy = 1'b0;
        end else begin
            o_data = w_fwd;
            o_busy = i_busy[i_idx] & ~w_hit;
        end
    end
endmodule

`default_nettype wire

// File: rtl/regfile_sb.sv
// ============================================================================
// Module      : regfile_sb
// Description : Multi-port register file with write-back forwarding and busy scoreboard.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int NREG   = DEFAULT_NREG,
    parameter int ADDR_W = $clog2(NREG),
    parameter int NRD    = 4,
    parameter int NWR    = 2
) (
    input  wire logic                    clk,
    input  wire logic                    reset,
    regfile_sb_if.slave                  bus,
    output logic      [NREG*DATA_W-1:0]  rf_o,
    output logic      [NREG-1:0]         busy_o
);
    logic [NREG-1:0][DATA_W-1:0] r_rf;
    logic [NREG-1:0]             r_busy;
    logic                        w_iss_wb_hit;
    logic                        w_iss_ready;

    always_comb begin
        w_iss_wb_hit = 1'b0;
        for (int p = 0; p < NWR; p++) begin
            if (bus.wb_en[p] && (bus.wb_idx[p*ADDR_W +: ADDR_W] == bus.iss_idx)) begin
                w_iss_wb_hit = 1'b1;
            end
        end
        w_iss_ready = (bus.iss_idx == ADDR_W'(ZERO_IDX)) | ~r_busy[bus.iss_idx] | w_iss_wb_hit;
    end

    assign bus.iss_ready = w_iss_ready;
    assign rf_o          = r_rf;
    assign busy_o        = r_busy;

    // Claim is applied after write-back so a same-cycle set overrides the clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rf   <= '0;
            r_busy <= '0;
        end else begin
            for (int p = 0; p < NWR; p++) begin
                if (bus.wb_en[p] && (bus.wb_idx[p*ADDR_W +: ADDR_W] != ADDR_W'(ZERO_IDX))) begin
                    r_rf[bus.wb_idx[p*ADDR_W +: ADDR_W]]   <= bus.wb_data[p*DATA_W +: DATA_W];
                    r_busy[bus.wb_idx[p*ADDR_W +: ADDR_W]] <= 1'b0;
                end
            end
            if (bus.iss_valid && w_iss_ready && (bus.iss_idx != ADDR_W'(ZERO_IDX))) begin
                r_busy[bus.iss_idx] <= 1'b1;
            end
        end
    end

    generate
        for (genvar k = 0; k < NRD; k++) begin : g_rd
            regfile_fwd_mux #(
                .DATA_W (DATA_W),
                .NREG   (NREG),
                .ADDR_W (ADDR_W),
                .NWR    (NWR)
            ) u_mux (
                .i_idx     (bus.rd_idx[k*ADDR_W +: ADDR_W]),
                .i_wb_en   (bus.wb_en),
                .i_wb_idx  (bus.wb_idx),
                .i_wb_data (bus.wb_data),
                .i_rf      (r_rf),
                .i_busy    (r_busy),
                .o_data    (bus.rd_data[k*DATA_W +: DATA_W]),
                .o_busy    (bus.rd_busy[k])
            );
        end
    endgenerate
endmodule

`default_nettype wire

// File: tb/tb_regfile_sb.sv
// ============================================================================
// Module      : tb_regfile_sb
// Description : Directed vector bench for regfile_sb.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_regfile_sb;
    import regfile_pkg::*;

    localparam int DW = 32;
    localparam int NR = 32;
    localparam int AW = 5;
    localparam int NRD = 4;
    localparam int NWR = 2;

    logic clk;
    logic reset;
    logic [NR*DW-1:0] rf_o;
    logic [NR-1:0]    busy_o;

    int n_checks;
    int n_err;

    regfile_sb_if #(.DATA_W(DW), .NREG(NR), .ADDR_W(AW), .NRD(NRD), .NWR(NWR)) ifc ();

    regfile_sb #(.DATA_W(DW), .NREG(NR), .ADDR_W(AW), .NRD(NRD), .NWR(NWR)) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (ifc),
        .rf_o   (rf_o),
        .busy_o (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  wb_en;
        logic [4:0]  wi0;
        logic [31:0] wd0;
        logic [4:0]  wi1;
        logic [31:0] wd1;
        logic [4:0]  rd;
        logic        iv;
        logic [4:0]  ii;
        logic [31:0] e_data;
        logic        e_rbusy;
        logic        e_ready;
        logic [4:0]  pidx;
        logic [31:0] e_rf;
        logic        e_busy;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        ifc.wb_en     = '0;
        ifc.wb_idx    = '0;
        ifc.wb_data   = '0;
        ifc.iss_valid = 1'b0;
        ifc.iss_idx   = '0;
        ifc.rd_idx    = '0;
    endtask

    task automatic set_rd_all(input logic [4:0] idx);
        for (int k = 0; k < NRD; k++) ifc.rd_idx[k*AW +: AW] = idx;
    endtask

    task automatic chk_rd_all(input string name, input logic [31:0] e_data, input logic e_busy);
        for (int k = 0; k < NRD; k++) begin
            chk($sformatf("%s rd_data[%0d]", name, k), ifc.rd_data[k*DW +: DW], e_data);
            chk($sformatf("%s rd_busy[%0d]", name, k), {31'd0, ifc.rd_busy[k]}, {31'd0, e_busy});
        end
    endtask

    initial begin
        n_checks = 0;
        n_err    = 0;
        reset    = 1'b0;
        drive_idle();

        //            en     wi0  wd0           wi1  wd1          rd  iv   ii   e_data        rb   rdy  pidx e_rf          busy
        vecs[0]  = '{2'b01, 5'd3, 32'h12345678, 5'd0, 32'h0,      5'd3, 1'b0, 5'd0, 32'h12345678, 1'b0, 1'b1, 5'd3, 32'h12345678, 1'b0};
        vecs[1]  = '{2'b11, 5'd7, 32'h1,        5'd7, 32'h2,      5'd7, 1'b0, 5'd0, 32'h2,        1'b0, 1'b1, 5'd7, 32'h2,        1'b0};
        vecs[2]  = '{2'b01, 5'd0, 32'hFFFFFFFF, 5'd0, 32'h0,      5'd0, 1'b1, 5'd0, 32'h0,        1'b0, 1'b1, 5'd0, 32'h0,        1'b0};
        vecs[3]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,      5'd9, 1'b1, 5'd9, 32'h0,        1'b0, 1'b1, 5'd9, 32'h0,        1'b1};
        vecs[4]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,      5'd9, 1'b1, 5'd9, 32'h0,        1'b1, 1'b0, 5'd9, 32'h0,        1'b1};
        vecs[5]  = '{2'b01, 5'd9, 32'hAA,       5'd0, 32'h0,      5'd9, 1'b0, 5'd9, 32'hAA,       1'b0, 1'b1, 5'd9, 32'hAA,       1'b0};
        vecs[6]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,      5'd3, 1'b1, 5'd4, 32'h12345678, 1'b0, 1'b1, 5'd4, 32'h0,        1'b1};
        vecs[7]  = '{2'b10, 5'd0, 32'h0,        5'd4, 32'h55,     5'd4, 1'b1, 5'd4, 32'h55,       1'b0, 1'b1, 5'd4, 32'h55,       1'b1};
        vecs[8]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,      5'd4, 1'b0, 5'd4, 32'h55,       1'b1, 1'b0, 5'd4, 32'h55,       1'b1};
        vecs[9]  = '{2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0,      5'd3, 1'b0, 5'd4, 32'h12345678, 1'b0, 1'b0, 5'd5, 32'hDEADBEEF, 1'b0};
        vecs[10] = '{2'b01, 5'd4, 32'h66,       5'd4, 32'h77,     5'd4, 1'b0, 5'd4, 32'h66,       1'b0, 1'b1, 5'd4, 32'h66,       1'b0};

        // Initial reset state
        #1;
        set_rd_all(5'd5);
        ifc.iss_idx = 5'd9;
        #1;
        chk("reset rf_o!=0", {31'd0, (rf_o != '0)}, 32'd0);
        chk("reset busy_o", busy_o, 32'h0);
        chk("reset iss_ready", {31'd0, ifc.iss_ready}, 32'd1);
        chk_rd_all("reset", 32'h0, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            drive_idle();
            ifc.wb_en            = vecs[i].wb_en;
            ifc.wb_idx[0 +: AW]  = vecs[i].wi0;
            ifc.wb_idx[AW +: AW] = vecs[i].wi1;
            ifc.wb_data[0 +: DW] = vecs[i].wd0;
            ifc.wb_data[DW +: DW] = vecs[i].wd1;
            ifc.iss_valid        = vecs[i].iv;
            ifc.iss_idx          = vecs[i].ii;
            set_rd_all(vecs[i].rd);
            #1;
            chk_rd_all($sformatf("v%0d", i), vecs[i].e_data, vecs[i].e_rbusy);
            chk($sformatf("v%0d iss_ready", i), {31'd0, ifc.iss_ready}, {31'd0, vecs[i].e_ready});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d rf_o[r%0d]", i, vecs[i].pidx),
                rf_unflatten(rf_o, int'(vecs[i].pidx)), vecs[i].e_rf);
            chk($sformatf("v%0d busy_o[r%0d]", i, vecs[i].pidx),
                {31'd0, busy_o[vecs[i].pidx]}, {31'd0, vecs[i].e_busy});
        end

        // Accumulated architectural state after the vector table
        chk("final r3", rf_unflatten(rf_o, 3), 32'h12345678);
        chk("final r0", rf_unflatten(rf_o, 0), 32'h0);
        chk("final busy_o", busy_o, 32'h0);

        // Mid-run asynchronous reset with a live producer and r5=DEADBEEF
        @(negedge clk);
        drive_idle();
        ifc.iss_valid = 1'b1;
        ifc.iss_idx   = 5'd9;
        @(posedge clk);
        #1;
        chk("pre-reset busy_o", busy_o, 32'h0000_0200);
        #2;
        drive_idle();
        ifc.iss_idx = 5'd9;
        set_rd_all(5'd5);
        reset = 1'b0;
        #1;
        chk("async reset rf_o!=0", {31'd0, (rf_o != '0)}, 32'd0);
        chk("async reset busy_o", busy_o, 32'h0);
        chk("async reset iss_ready", {31'd0, ifc.iss_ready}, 32'd1);
        chk_rd_all("async reset r5", 32'h0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("post-reset busy_o", busy_o, 32'h0);
        chk("post-reset r5", rf_unflatten(rf_o, 5), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule

`default_nettype wire

// File: doc/regfile_sb.md
# regfile_sb

Multi-port general-purpose register file with an integrated busy scoreboard. It is the parametrised successor of the single-issue register file: N read ports, M write-back ports, same-cycle write-to-read forwarding, and an issue/write-back handshake that tracks which registers have an in-flight producer. It sits between decode/issue (reads, busy checks, destination claim) and the write-back stage, and exports the architectural state for difftest.

## Interface
- DATA_W, 32, register width in bits
- NREG, 32, number of architectural registers (power of two, ≥ 2)
- ADDR_W, $clog2(NREG), register index width
- NRD, 4, number of read ports
- NWR, 2, number of write-back ports
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- rd_idx  in  NRD*ADDR_W  read indices, port k at [k*ADDR_W +: ADDR_W]
- rd_data  out  NRD*DATA_W  read data, combinational
- rd_busy  out  NRD  source k has an in-flight producer after this cycle's write-back
- wb_en  in  NWR  write-back valid per port
- wb_idx  in  NWR*ADDR_W  write-back destination
- wb_data  in  NWR*DATA_W  write-back data
- iss_valid  in  1  issue stage claims a destination
- iss_idx  in  ADDR_W  destination being claimed
- iss_ready  out  1  claim accepted this cycle
- rf_o  out  NREG*DATA_W  architectural state for difftest, register r at [r*DATA_W +: DATA_W]
- busy_o  out  NREG  scoreboard state

## Operation
- Register 0: reads return 0, writes ignored, never busy, always claimable.
- Write-back: on rising edge, for each port with wb_en=1 and wb_idx≠0, rf[wb_idx] <= wb_data and busy[wb_idx] <= 0.
- Write conflict: two enabled ports with equal index → highest-numbered port wins data; busy still cleared.
- Read: rd_data[k] = 0 if idx=0; else forwarded wb_data of highest-numbered enabled port matching idx; else rf[idx].
- rd_busy[k] = busy[idx] & no enabled write-back to idx this cycle; 0 for idx=0.
- Claim: iss_ready = (iss_idx=0) | ~busy[iss_idx] | (any wb_en with wb_idx=iss_idx). Transfer on iss_valid & iss_ready; iss_idx≠0 → busy[iss_idx] <= 1.
- Simultaneous clear (write-back) and set (claim) of the same register: set wins, busy=1 next cycle, data is the write-back value.
- Claim to a busy register with no matching write-back: iss_ready=0, no state change (WAW prevented here).
- iss_ready is independent of iss_valid.

## Timing
- Reset (reset=0, asynchronous): all rf entries 0, all busy 0; rf_o=0, busy_o=0, iss_ready=1, rd_busy=0, rd_data=0 for all indices.
- Reset deasserted mid-flight: in-flight producers are forgotten; no ordering with write-back is guaranteed, upstream flushes with reset.
- Read latency 0 cycles (combinational, includes same-cycle forwarding).
- Write latency 1 cycle: rf_o and busy_o reflect write-back/claim after the edge.
- Combinational paths: rd_idx, wb_* → rd_data, rd_busy; iss_idx, wb_* → iss_ready. No path from iss_valid to any output.

## Structure
- Shared package regfile_pkg: default DATA_W/NREG constants, zero-register index constant, difftest flatten/unflatten helper functions.
- One sub-module: regfile_fwd_mux (one read port: index-zero check, priority forwarding across NWR ports, array fallback, busy qualification), instantiated NRD times via generate.
- Storage and scoreboard vector live in the top; all ports generated from parameters, no hard-coded counts.

## Test plan
- Reset: drive reset=0 mid-run after writing r5=0xDEADBEEF → rf_o all 0, busy_o=0, iss_ready=1, rd_data for r5 = 0 immediately.
- Write/read/forward: wb port0 r3=0x12345678 with rd_idx0=3 same cycle → rd_data0=0x12345678 combinationally; next cycle rf_o[r3]=0x12345678.
- Write conflict: port0 r7=0x1, port1 r7=0x2 same cycle, read r7 same cycle → rd_data=0x2; r7=0x2 afterward.
- Register 0: write r0=0xFFFFFFFF, claim r0 → rd_data=0, busy_o[0]=0, iss_ready=1.
- Scoreboard: claim r9 → next cycle busy_o[9]=1, rd_busy=1 for r9, second claim r9 gets iss_ready=0; write-back r9=0xAA → same cycle rd_busy=0 and iss_ready=1, next cycle busy_o[9]=0.
- Set/clear collision: r4 busy, write-back r4=0x55 and claim r4 same cycle → iss_ready=1, next cycle busy_o[4]=1, rf_o[r4]=0x55.
